// File: rtl/matrix_checker_pkg.sv
// Shared state encoding and ready-pattern selectors for the AXI-Stream result checker.
`timescale 1ns/1ps
package matrix_checker_pkg;

    typedef enum logic [1:0] {
        ST_DELAY = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int READY_ALWAYS = 0;
    localparam int READY_TOGGLE = 1;

endpackage

// File: rtl/sat_counter.sv
// Enable-incrementing counter that sticks at all-ones instead of wrapping.
`timescale 1ns/1ps
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/axis_result_checker.sv
// AXI-Stream sink that checks result frames against an arithmetic sequence and
// reports data/length errors, frames seen and a sticky done/pass verdict.
`timescale 1ns/1ps
module axis_result_checker
    import matrix_checker_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CMP_W       = 8,
    parameter int EXP_BASE    = 12,
    parameter int EXP_STEP    = 0,
    parameter int FRAME_LEN   = 16,
    parameter int NUM_FRAMES  = 1,
    parameter int START_DELAY = 20000,
    parameter int READY_MODE  = 0,
    parameter int ERR_W       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              output_r_TVALID,
    input  logic              output_r_TLAST,
    input  logic [DATA_W-1:0] output_r_TDATA,
    output logic              output_r_TREADY,
    output logic [ERR_W-1:0]  data_err_count,
    output logic [ERR_W-1:0]  len_err_count,
    output logic [15:0]       frame_count,
    output logic              done,
    output logic              pass
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int DLY_W = $clog2(START_DELAY + 2);
    localparam int FRM_W = $clog2(NUM_FRAMES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CMP_W-1:0] BASE_C   = CMP_W'(EXP_BASE);
    localparam logic [CMP_W-1:0] STEP_C   = CMP_W'(EXP_STEP);
    localparam logic [DLY_W-1:0] DLY_END  = DLY_W'(START_DELAY);
    localparam logic [FRM_W-1:0] FRM_END  = FRM_W'(NUM_FRAMES - 1);

    state_e            state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              drain_q, drain_d;
    logic [FRM_W-1:0]  frames_q, frames_d;
    logic              tready_q, tready_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CMP_W-1:0]  exp_q, exp_d;
    logic              s1_valid_q, s1_valid_d;
    logic [CMP_W-1:0]  s1_data_q, s1_data_d;
    logic              s1_last_q, s1_last_d;
    logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
    logic [CMP_W-1:0]  s1_exp_q, s1_exp_d;
    logic              s2_derr_q, s2_derr_d;
    logic              s2_lerr_q, s2_lerr_d;
    logic              s2_close_q, s2_close_d;

    logic accept;
    logic close;
    logic s1_at_last;
    logic unused_tdata;

    assign accept       = output_r_TVALID & tready_q;
    assign close        = accept & (output_r_TLAST | (idx_q == LAST_IDX));
    assign s1_at_last   = (s1_idx_q == LAST_IDX);
    assign unused_tdata = ^output_r_TDATA;

    // Frame closes are tracked at accept time so TREADY drops right after the final beat.
    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        drain_d  = drain_q;
        frames_d = frames_q;
        tready_d = 1'b0;
        done_d   = done_q;
        case (state_q)
            ST_DELAY: begin
                if (dly_q == DLY_END) begin
                    state_d  = ST_RUN;
                    tready_d = 1'b1;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_RUN: begin
                tready_d = (READY_MODE == READY_TOGGLE) ? ~tready_q : 1'b1;
                if (close) begin
                    if (frames_q == FRM_END) begin
                        state_d  = ST_DRAIN;
                        tready_d = 1'b0;
                    end else begin
                        frames_d = frames_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                done_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_DELAY;
            dly_q    <= '0;
            drain_q  <= 1'b0;
            frames_q <= '0;
            tready_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            drain_q  <= drain_d;
            frames_q <= frames_d;
            tready_q <= tready_d;
            done_q   <= done_d;
        end
    end

    // Expected value is accumulated per accepted beat, so no multiplier is needed.
    always_comb begin
        idx_d = idx_q;
        exp_d = exp_q;
        if (close) begin
            idx_d = '0;
            exp_d = BASE_C;
        end else if (accept) begin
            idx_d = idx_q + 1'b1;
            exp_d = exp_q + STEP_C;
        end
        s1_valid_d = accept;
        s1_data_d  = output_r_TDATA[CMP_W-1:0];
        s1_last_d  = output_r_TLAST;
        s1_idx_d   = idx_q;
        s1_exp_d   = exp_q;
        s2_derr_d  = s1_valid_q & (s1_data_q != s1_exp_q);
        s2_lerr_d  = s1_valid_q & (s1_last_q != s1_at_last);
        s2_close_d = s1_valid_q & (s1_last_q | s1_at_last);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q      <= '0;
            exp_q      <= BASE_C;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_last_q  <= 1'b0;
            s1_idx_q   <= '0;
            s1_exp_q   <= '0;
            s2_derr_q  <= 1'b0;
            s2_lerr_q  <= 1'b0;
            s2_close_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            exp_q      <= exp_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_last_q  <= s1_last_d;
            s1_idx_q   <= s1_idx_d;
            s1_exp_q   <= s1_exp_d;
            s2_derr_q  <= s2_derr_d;
            s2_lerr_q  <= s2_lerr_d;
            s2_close_q <= s2_close_d;
        end
    end

    sat_counter #(.W(ERR_W)) u_data_err (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (s2_derr_q),
        .count   (data_err_count)
    );

    sat_counter #(.W(ERR_W)) u_len_err (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (s2_lerr_q),
        .count   (len_err_count)
    );

    sat_counter #(.W(16)) u_frame_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (s2_close_q),
        .count   (frame_count)
    );

    assign output_r_TREADY = tready_q;
    assign done            = done_q;
    assign pass            = done_q && (data_err_count == '0) && (len_err_count == '0);

endmodule

// File: tb/tb_axis_result_checker.sv
// Bench for axis_result_checker: a constant-pattern instance (A) and a ramp-pattern,
// toggling-ready, 2-bit-error-counter instance (B) checked against a behavioural model.
`timescale 1ns/1ps
module tb_axis_result_checker;

    localparam int B_BASE = 0;
    localparam int B_STEP = 1;
    localparam int B_LEN  = 16;
    localparam int B_ERRW = 2;

    logic        clk;
    logic        a_rst_n, a_tvalid, a_tlast, a_ready, a_done, a_pass;
    logic [31:0] a_tdata;
    logic [7:0]  a_derr, a_lerr;
    logic [15:0] a_fcnt;
    logic        b_rst_n, b_tvalid, b_tlast, b_ready, b_done, b_pass;
    logic [15:0] b_tdata;
    logic [1:0]  b_derr, b_lerr;
    logic [15:0] b_fcnt;

    int passed = 0;
    int total  = 0;
    int m_idx  = 0;
    int m_derr = 0;
    int m_lerr = 0;
    int m_frames = 0;

    axis_result_checker #(
        .DATA_W(32), .CMP_W(8), .EXP_BASE(12), .EXP_STEP(0), .FRAME_LEN(16),
        .NUM_FRAMES(1), .START_DELAY(10), .READY_MODE(0), .ERR_W(8)
    ) u_a (
        .clk(clk), .reset_n(a_rst_n), .output_r_TVALID(a_tvalid), .output_r_TLAST(a_tlast),
        .output_r_TDATA(a_tdata), .output_r_TREADY(a_ready), .data_err_count(a_derr),
        .len_err_count(a_lerr), .frame_count(a_fcnt), .done(a_done), .pass(a_pass)
    );

    axis_result_checker #(
        .DATA_W(16), .CMP_W(8), .EXP_BASE(B_BASE), .EXP_STEP(B_STEP), .FRAME_LEN(B_LEN),
        .NUM_FRAMES(3), .START_DELAY(2), .READY_MODE(1), .ERR_W(B_ERRW)
    ) u_b (
        .clk(clk), .reset_n(b_rst_n), .output_r_TVALID(b_tvalid), .output_r_TLAST(b_tlast),
        .output_r_TDATA(b_tdata), .output_r_TREADY(b_ready), .data_err_count(b_derr),
        .len_err_count(b_lerr), .frame_count(b_fcnt), .done(b_done), .pass(b_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int sat_n(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic [7:0] b_expected();
        return 8'(B_BASE + m_idx * B_STEP);
    endfunction

    // Reference behaviour for one accepted beat on B.
    task automatic b_model_accept(input bit bad, input logic last);
        if (bad) m_derr++;
        if (last != (m_idx == B_LEN - 1)) m_lerr++;
        if (last || (m_idx == B_LEN - 1)) begin
            m_idx = 0;
            m_frames++;
        end else begin
            m_idx++;
        end
    endtask

    task automatic a_send(input logic [7:0] low, input logic last);
        logic rdy;
        int tries;
        tries = 0;
        a_tvalid = 1'b1;
        a_tdata  = {24'($urandom), low};
        a_tlast  = last;
        do begin
            rdy = a_ready;
            @(negedge clk);
            tries++;
        end while (!rdy && tries < 40);
        if (!rdy) begin
            total++;
            $display("FAIL a_handshake_timeout: ready got 0 required 1");
        end
        a_tvalid = 1'b0;
        a_tlast  = 1'b0;
    endtask

    task automatic b_send(input bit bad, input logic last);
        logic rdy;
        logic [7:0] low;
        int tries;
        tries = 0;
        low = b_expected();
        if (bad) low = low ^ 8'($urandom_range(1, 255));
        b_tvalid = 1'b1;
        b_tdata  = {8'($urandom), low};
        b_tlast  = last;
        do begin
            rdy = b_ready;
            @(negedge clk);
            tries++;
        end while (!rdy && tries < 40);
        if (!rdy) begin
            total++;
            $display("FAIL b_handshake_timeout: ready got 0 required 1");
        end else begin
            b_model_accept(bad, last);
        end
        b_tvalid = 1'b0;
        b_tlast  = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic a_restart();
        int w;
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
        w = 0;
        while (!a_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (a_ready !== 1'b1) $display("FAIL a_restart_ready: got %0b required 1", a_ready);
        else passed++;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({a_ready, a_done, a_pass} !== 3'b000)
            $display("FAIL reset_a_flags: got %b required 000", {a_ready, a_done, a_pass});
        else passed++;
        total++;
        if ({a_derr, a_lerr, a_fcnt} !== 32'd0)
            $display("FAIL reset_a_counts: got %h required 0", {a_derr, a_lerr, a_fcnt});
        else passed++;
        total++;
        if ({b_ready, b_done, b_pass, b_derr, b_lerr, b_fcnt} !== 23'd0)
            $display("FAIL reset_b_outputs: got %h required 0", {b_ready, b_done, b_pass, b_derr, b_lerr, b_fcnt});
        else passed++;
    endtask

    task automatic test_start_delay();
        logic exp_rdy;
        a_rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_rdy = (k > 10);
            total++;
            if (a_ready !== exp_rdy)
                $display("FAIL start_delay_ready k=%0d: got %0b required %0b", k, a_ready, exp_rdy);
            else passed++;
        end
    endtask

    task automatic test_clean_frame();
        int w;
        for (int i = 0; i < 16; i++) a_send(8'd12, i == 15);
        w = 0;
        while (!a_done && w < 10) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (a_done !== 1'b1) $display("FAIL clean_done: got %0b required 1", a_done);
        else passed++;
        total++;
        if (a_derr !== 8'd0 || a_lerr !== 8'd0)
            $display("FAIL clean_errs: got d=%0d l=%0d required 0/0", a_derr, a_lerr);
        else passed++;
        total++;
        if (a_fcnt !== 16'd1) $display("FAIL clean_frames: got %0d required 1", a_fcnt);
        else passed++;
        total++;
        if (a_pass !== 1'b1 || a_ready !== 1'b0)
            $display("FAIL clean_pass_ready: got pass=%0b ready=%0b required 1/0", a_pass, a_ready);
        else passed++;
        a_tvalid = 1'b1;
        a_tdata  = 32'hFFFF_FF0D;
        a_tlast  = 1'b1;
        repeat (4) @(negedge clk);
        a_tvalid = 1'b0;
        a_tlast  = 1'b0;
        total++;
        if (a_derr !== 8'd0 || a_fcnt !== 16'd1 || a_done !== 1'b1)
            $display("FAIL done_ignores_valid: got d=%0d f=%0d done=%0b required 0/1/1", a_derr, a_fcnt, a_done);
        else passed++;
    endtask

    task automatic test_data_errors();
        int exp_cnt, w;
        a_restart();
        for (int c = 0; c < 16; c++) begin
            total++;
            if (a_ready !== 1'b1) $display("FAIL derr_ready beat=%0d: got %0b required 1", c, a_ready);
            else passed++;
            a_tvalid = 1'b1;
            a_tdata  = {24'($urandom), ((c == 3) || (c == 7)) ? 8'h0D : 8'd12};
            a_tlast  = (c == 15);
            @(negedge clk);
            exp_cnt = 0;
            for (int j = 0; j <= c - 2; j++) if ((j == 3) || (j == 7)) exp_cnt++;
            total++;
            if (a_derr !== 8'(exp_cnt))
                $display("FAIL derr_latency edge=%0d: got %0d required %0d", c, a_derr, exp_cnt);
            else passed++;
        end
        a_tvalid = 1'b0;
        a_tlast  = 1'b0;
        w = 0;
        while (!a_done && w < 10) begin
            @(negedge clk);
            w++;
        end
        total++;
        if ({a_done, a_pass} !== 2'b10 || a_derr !== 8'd2 || a_lerr !== 8'd0)
            $display("FAIL derr_final: got done=%0b pass=%0b d=%0d l=%0d required 1/0/2/0", a_done, a_pass, a_derr, a_lerr);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        a_restart();
        a_send(8'h55, 1'b0);
        a_send(8'd12, 1'b0);
        a_send(8'd12, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if (a_derr !== 8'd1) $display("FAIL midframe_pre: got %0d required 1", a_derr);
        else passed++;
        a_tvalid = 1'b1;
        a_tdata  = 32'd12;
        #2;
        a_rst_n = 1'b0;
        #1;
        total++;
        if ({a_ready, a_done, a_pass, a_derr, a_lerr, a_fcnt} !== 35'd0)
            $display("FAIL midframe_async_reset: got %h required 0", {a_ready, a_done, a_pass, a_derr, a_lerr, a_fcnt});
        else passed++;
        a_tvalid = 1'b0;
    endtask

    task automatic test_ready_toggle();
        logic rdy_before, exp_rdy;
        int k, beats;
        k = 0;
        beats = 0;
        @(negedge clk);
        b_rst_n  = 1'b1;
        b_tvalid = 1'b1;
        b_tdata  = {8'($urandom), b_expected()};
        b_tlast  = 1'b0;
        while (beats < B_LEN && k < 100) begin
            rdy_before = b_ready;
            @(negedge clk);
            k++;
            if (rdy_before) begin
                b_model_accept(1'b0, b_tlast);
                beats++;
                b_tdata = {8'($urandom), b_expected()};
                b_tlast = (beats == B_LEN - 1);
            end
            exp_rdy = (k > 2) && (((k - 3) % 2) == 0);
            total++;
            if (b_ready !== exp_rdy)
                $display("FAIL toggle_ready k=%0d: got %0b required %0b", k, b_ready, exp_rdy);
            else passed++;
        end
        b_tvalid = 1'b0;
        b_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (b_derr !== 2'(sat_n(m_derr, B_ERRW)) || b_lerr !== 2'(sat_n(m_lerr, B_ERRW)) || b_fcnt !== 16'(m_frames))
            $display("FAIL toggle_frame: got d=%0d l=%0d f=%0d required %0d/%0d/%0d",
                     b_derr, b_lerr, b_fcnt, sat_n(m_derr, B_ERRW), sat_n(m_lerr, B_ERRW), m_frames);
        else passed++;
        total++;
        if (b_done !== 1'b0) $display("FAIL toggle_not_done: got %0b required 0", b_done);
        else passed++;
    endtask

    task automatic test_len_error();
        for (int i = 0; i < 10; i++) b_send(1'b0, i == 9);
        repeat (4) @(negedge clk);
        total++;
        if (b_lerr !== 2'(sat_n(m_lerr, B_ERRW)) || b_fcnt !== 16'(m_frames) || b_derr !== 2'(sat_n(m_derr, B_ERRW)))
            $display("FAIL len_err_early_last: got l=%0d f=%0d d=%0d required %0d/%0d/%0d",
                     b_lerr, b_fcnt, b_derr, sat_n(m_lerr, B_ERRW), m_frames, sat_n(m_derr, B_ERRW));
        else passed++;
    endtask

    task automatic test_saturation();
        bit bad_mask [16];
        int nbad, p, w;
        foreach (bad_mask[i]) bad_mask[i] = 1'b0;
        nbad = 0;
        while (nbad < 5) begin
            p = $urandom_range(8, 15);
            if (!bad_mask[p]) begin
                bad_mask[p] = 1'b1;
                nbad++;
            end
        end
        for (int i = 0; i < 8; i++) b_send(1'b0, 1'b0);
        repeat (4) @(negedge clk);
        total++;
        if (b_derr !== 2'(sat_n(m_derr, B_ERRW)))
            $display("FAIL restart_after_len_err: got d=%0d required %0d", b_derr, sat_n(m_derr, B_ERRW));
        else passed++;
        for (int i = 8; i < 16; i++) b_send(bad_mask[i], i == 15);
        w = 0;
        while (!b_done && w < 10) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (b_done !== 1'b1 || b_ready !== 1'b0)
            $display("FAIL sat_done: got done=%0b ready=%0b required 1/0", b_done, b_ready);
        else passed++;
        total++;
        if (b_derr !== 2'(sat_n(m_derr, B_ERRW)))
            $display("FAIL sat_data_err: got %0d required %0d", b_derr, sat_n(m_derr, B_ERRW));
        else passed++;
        total++;
        if (b_lerr !== 2'(sat_n(m_lerr, B_ERRW)) || b_fcnt !== 16'(m_frames) || b_pass !== 1'b0)
            $display("FAIL sat_final: got l=%0d f=%0d pass=%0b required %0d/%0d/0",
                     b_lerr, b_fcnt, b_pass, sat_n(m_lerr, B_ERRW), m_frames);
        else passed++;
    endtask

    initial begin
        a_tvalid = 1'b0;
        a_tlast  = 1'b0;
        a_tdata  = '0;
        b_tvalid = 1'b0;
        b_tlast  = 1'b0;
        b_tdata  = '0;
        a_rst_n  = 1'b0;
        b_rst_n  = 1'b0;
        test_reset();
        test_start_delay();
        test_clean_frame();
        test_data_errors();
        test_reset_mid_frame();
        test_ready_toggle();
        test_len_error();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
